// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Round-robin arbiter granting one 8-way one-hot select
//                resource to one of 8 requesters at a time. The grant is
//                held until the owner drops its request or, when MAX_HOLD
//                is non-zero, until the owner has held it for MAX_HOLD
//                consecutive cycles. Exactly one idle cycle separates any
//                two grants.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_HOLD    : max consecutive grant cycles per owner (0 = unlimited),
//                  legal range 0..255
//  Ports
//    clk         : in  1  system clock, rising edge
//    rst         : in  1  asynchronous active-high reset
//    req         : in  8  request vector, req[i] = requester i wants access
//    grant       : out 8  registered one-hot grant, zero when no owner
//    grant_idx   : out 3  registered binary owner index (valid with
//                         grant_valid)
//    grant_valid : out 1  high while a grant is asserted
//    preempt     : out 1  one-cycle pulse after a MAX_HOLD forced release
// ============================================================================
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_max_hold = MAX_HOLD[7:0];
    localparam logic [7:0] c_hold_sat = 8'd255;

    state_t     state_q,       state_d;
    logic [7:0] grant_q,       grant_d;
    logic [2:0] grant_idx_q,   grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       preempt_q,     preempt_d;
    logic [7:0] hold_q,        hold_d;
    logic [2:0] last_q,        last_d;

    logic       w_found;
    logic [2:0] w_pick;

    // Rotating priority search: candidates are visited in the order
    // last+1, last+2, ..., last (3-bit wrap), so the previous owner is
    // always the lowest priority. The first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] cand;
            cand = last_q + 3'(k);
            if (!w_found && req[cand]) begin
                w_found = 1'b1;
                w_pick  = cand;
            end
        end
    end

    // Next-state logic. Every release path goes back to IDLE with all grant
    // outputs cleared, which produces the mandatory idle cycle between
    // consecutive owners.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;
        hold_d        = hold_q;
        last_d        = last_q;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d       = ST_BUSY;
                    grant_d       = 8'd1 << w_pick;
                    grant_idx_d   = w_pick;
                    grant_valid_d = 1'b1;
                    last_d        = w_pick;
                    hold_d        = 8'd1;
                end
            end

            ST_BUSY: begin
                if (!req[grant_idx_q]) begin
                    // Owner gave the resource back voluntarily.
                    state_d       = ST_IDLE;
                    grant_d       = 8'd0;
                    grant_idx_d   = 3'd0;
                    grant_valid_d = 1'b0;
                end else if ((c_max_hold != 8'd0) && (hold_q == c_max_hold)) begin
                    // Hold budget exhausted: take the grant away and flag it.
                    state_d       = ST_IDLE;
                    grant_d       = 8'd0;
                    grant_idx_d   = 3'd0;
                    grant_valid_d = 1'b0;
                    preempt_d     = 1'b1;
                end else begin
                    // Saturate so an unlimited hold never wraps the counter.
                    if (hold_q != c_hold_sat) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d       = ST_IDLE;
                grant_d       = 8'd0;
                grant_idx_d   = 3'd0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // Reset leaves the pointer at 7 so the first search begins at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 8'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
            hold_q        <= 8'd0;
            last_q        <= 3'd7;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
            hold_q        <= hold_d;
            last_q        <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8. One instance uses the
//                default MAX_HOLD of 15, a second uses MAX_HOLD = 4. Each
//                scenario task pushes the expected outputs into a scoreboard
//                queue as it drives a request pattern, then pops and compares
//                after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       preempt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    logic [7:0] req4;
    logic [7:0] grant4;
    logic [2:0] grant_idx4;
    logic       grant_valid4;
    logic       preempt4;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] exp_grant;
    int         total;
    int         bad;

    rr_arbiter8 #(.MAX_HOLD(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .req         (req4),
        .grant       (grant4),
        .grant_idx   (grant_idx4),
        .grant_valid (grant_valid4),
        .preempt     (preempt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input int i, input logic p);
        exp_t t;
        t.valid   = v;
        t.idx     = 3'(i);
        t.preempt = p;
        return t;
    endfunction

    // Reset pulse that is released away from a clock edge.
    task automatic do_reset();
        req  = 8'h00;
        req4 = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        req  = 8'h00;
        req4 = 8'h00;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (grant !== 8'h00 || grant_idx !== 3'd0 || grant_valid !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL reset_main: grant=%h idx=%0d valid=%b preempt=%b, want 00/0/0/0",
                     grant, grant_idx, grant_valid, preempt);
        end
        total++;
        if (grant4 !== 8'h00 || grant_idx4 !== 3'd0 || grant_valid4 !== 1'b0 || preempt4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold4: grant=%h idx=%0d valid=%b preempt=%b, want 00/0/0/0",
                     grant4, grant_idx4, grant_valid4, preempt4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single requester: grant one cycle after req, release one edge after drop.
    task automatic test_single();
        logic [7:0] rq [3];
        exp_t       ex [3];
        rq[0] = 8'h01; ex[0] = mk(1'b1, 0, 1'b0);
        rq[1] = 8'h00; ex[1] = mk(1'b0, 0, 1'b0);
        rq[2] = 8'h00; ex[2] = mk(1'b0, 0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            req = rq[s];
            sb.push_back(ex[s]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
            total++;
            if (grant !== exp_grant || grant_valid !== e.valid ||
                (e.valid && grant_idx !== e.idx) || preempt !== e.preempt) begin
                bad++;
                $display("FAIL single step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                         s, grant, grant_idx, grant_valid, preempt, exp_grant, e.idx, e.valid, e.preempt);
            end
        end
    endtask

    // All request; each owner holds 3 cycles then drops for one cycle.
    task automatic test_round_robin();
        int owner;
        do_reset();
        for (int n = 0; n < 9; n++) begin
            owner = n % 8;
            for (int s = 0; s < 4; s++) begin
                if (s == 3) begin
                    req = 8'hFF & ~(8'd1 << owner);
                    sb.push_back(mk(1'b0, 0, 1'b0));
                end else begin
                    req = 8'hFF;
                    sb.push_back(mk(1'b1, owner, 1'b0));
                end
                @(posedge clk);
                #1;
                e = sb.pop_front();
                exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
                total++;
                if (grant !== exp_grant || grant_valid !== e.valid ||
                    (e.valid && grant_idx !== e.idx) || preempt !== e.preempt) begin
                    bad++;
                    $display("FAIL rr owner%0d step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                             owner, s, grant, grant_idx, grant_valid, preempt, exp_grant, e.idx, e.valid, e.preempt);
                end
            end
        end
    endtask

    // Owner 5 hogs with requester 2 waiting; forced off after 15 cycles.
    task automatic test_preempt();
        do_reset();
        for (int s = 0; s < 18; s++) begin
            if (s == 0) begin
                req = 8'h20;
                sb.push_back(mk(1'b1, 5, 1'b0));
            end else if (s < 15) begin
                req = 8'h24;
                sb.push_back(mk(1'b1, 5, 1'b0));
            end else if (s == 15) begin
                req = 8'h24;
                sb.push_back(mk(1'b0, 0, 1'b1));
            end else if (s == 16) begin
                req = 8'h24;
                sb.push_back(mk(1'b1, 2, 1'b0));
            end else begin
                req = 8'h00;
                sb.push_back(mk(1'b0, 0, 1'b0));
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
            total++;
            if (grant !== exp_grant || grant_valid !== e.valid ||
                (e.valid && grant_idx !== e.idx) || preempt !== e.preempt) begin
                bad++;
                $display("FAIL preempt step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                         s, grant, grant_idx, grant_valid, preempt, exp_grant, e.idx, e.valid, e.preempt);
            end
        end
    endtask

    // Lone requester 3 on the MAX_HOLD=4 instance: 4 grant, 1 preempt idle.
    task automatic test_hold_limit();
        do_reset();
        for (int s = 0; s < 16; s++) begin
            if (s == 15) begin
                req4 = 8'h00;
                sb.push_back(mk(1'b0, 0, 1'b0));
            end else if ((s % 5) < 4) begin
                req4 = 8'h08;
                sb.push_back(mk(1'b1, 3, 1'b0));
            end else begin
                req4 = 8'h08;
                sb.push_back(mk(1'b0, 0, 1'b1));
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
            total++;
            if (grant4 !== exp_grant || grant_valid4 !== e.valid ||
                (e.valid && grant_idx4 !== e.idx) || preempt4 !== e.preempt) begin
                bad++;
                $display("FAIL hold4 step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                         s, grant4, grant_idx4, grant_valid4, preempt4, exp_grant, e.idx, e.valid, e.preempt);
            end
        end
    endtask

    // After owner 6 releases, requests 6 and 0 together: 0 must win.
    task automatic test_wrap();
        logic [7:0] rq [4];
        exp_t       ex [4];
        rq[0] = 8'h40; ex[0] = mk(1'b1, 6, 1'b0);
        rq[1] = 8'h00; ex[1] = mk(1'b0, 0, 1'b0);
        rq[2] = 8'h41; ex[2] = mk(1'b1, 0, 1'b0);
        rq[3] = 8'h00; ex[3] = mk(1'b0, 0, 1'b0);
        do_reset();
        for (int s = 0; s < 4; s++) begin
            req = rq[s];
            sb.push_back(ex[s]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
            total++;
            if (grant !== exp_grant || grant_valid !== e.valid ||
                (e.valid && grant_idx !== e.idx) || preempt !== e.preempt) begin
                bad++;
                $display("FAIL wrap step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                         s, grant, grant_idx, grant_valid, preempt, exp_grant, e.idx, e.valid, e.preempt);
            end
        end
    endtask

    // Async reset while owner 4 holds; pointer must return to 7 afterwards.
    task automatic test_async_reset();
        logic [7:0] rq [4];
        exp_t       ex [4];
        rq[0] = 8'h10; ex[0] = mk(1'b1, 4, 1'b0);
        rq[1] = 8'h10; ex[1] = mk(1'b1, 4, 1'b0);
        rq[2] = 8'h90; ex[2] = mk(1'b1, 4, 1'b0);
        rq[3] = 8'h00; ex[3] = mk(1'b0, 0, 1'b0);
        do_reset();
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                #2;
                rst = 1'b1;
                #1;
                total++;
                if (grant !== 8'h00 || grant_valid !== 1'b0 || preempt !== 1'b0) begin
                    bad++;
                    $display("FAIL async_reset: grant=%h valid=%b preempt=%b, want 00/0/0",
                             grant, grant_valid, preempt);
                end
                req = 8'h90;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            req = rq[s];
            sb.push_back(ex[s]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_grant = e.valid ? (8'd1 << e.idx) : 8'd0;
            total++;
            if (grant !== exp_grant || grant_valid !== e.valid ||
                (e.valid && grant_idx !== e.idx) || preempt !== e.preempt) begin
                bad++;
                $display("FAIL async step%0d: grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                         s, grant, grant_idx, grant_valid, preempt, exp_grant, e.idx, e.valid, e.preempt);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_hold_limit();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Round-robin arbiter sharing one 8-way one-hot select resource among 8 requesters. It produces a registered 3-bit owner index and the matching one-hot grant vector, which is the same encoding our 3-to-8 decode stage drives. The arbiter holds a grant until the owner drops its request or a hold limit expires. It sits in front of any shared 8-slot resource (bus, display digit, channel mux) so that only one requester drives it at a time.

Parameters:
MAX_HOLD, 15, maximum consecutive cycles one owner may keep the grant. 0 means unlimited. Legal range is 0..255.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  8  request vector; req[i] high means requester i wants the resource.
grant  output  8  one-hot grant, registered; all zero when no owner.
grant_idx  output  3  binary index of the current owner, registered; valid only when grant_valid is high.
grant_valid  output  1  high while any grant is asserted.
preempt  output  1  one-cycle pulse when a grant is forcibly removed by the MAX_HOLD limit.

Behaviour:
- Reset (asynchronous, on rst high):
  - grant=8'd0, grant_idx=3'd0, grant_valid=0, preempt=0.
  - State=IDLE, hold counter=0, last-owner pointer=3'd7, so the first search starts at index 0.
- Invariant: grant == (8'd1 << grant_idx) when grant_valid=1; grant == 8'd0 otherwise. Never more than one grant bit set.
- States: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching last+1, last+2, … with modulo-8 wrap. last itself is checked last.
  - At that clock edge: grant, grant_idx and grant_valid are loaded; last:=i; hold counter:=1; go to BUSY.
  - Latency: a req rising before edge N gives grant visible after edge N (1 cycle).
- BUSY, evaluated each edge in this priority order:
  1. req[grant_idx]=0: release. Outputs clear at this edge; go to IDLE; preempt=0.
  2. MAX_HOLD≠0 and hold counter==MAX_HOLD: forced release. Outputs clear; preempt=1 for this one cycle; go to IDLE.
  3. Otherwise keep the grant and increment the hold counter (8-bit, saturating at 255).
- There is exactly one idle cycle (grant_valid=0) between consecutive grants. No direct handover.
- After a preempt, the previous owner is lowest priority in the next arbitration. If it is the only requester, it is re-granted after the one idle cycle.
- Changes to other req bits while in BUSY have no effect until the next IDLE cycle.
- preempt is 0 in every cycle except the one following a forced release.
- rst asserted mid-grant clears all outputs immediately (no clock needed). After reset the pointer is back at 7.
- req is treated as synchronous to clk. Requesters must hold req high until granted; dropping req before the grant simply removes it from arbitration.

Test Plan:
1. Reset with req=8'h00, then apply req=8'h01 → grant=8'h01, grant_idx=0 one cycle later. Drop req → grant=8'h00 at the next edge.
2. req=8'hFF held, each owner drops its req 3 cycles after being granted → grant sequence idx 0,1,2,…,7,0 with one idle cycle between each.
3. Owner 5 holds, req=8'h24 continuously, MAX_HOLD=15:
   - grant_idx=5 for exactly 15 cycles, then preempt=1 for one cycle with grant=8'h00.
   - Next grant goes to idx 2.
4. Only req[3] held forever with MAX_HOLD=4 → pattern of 4 grant cycles, 1 idle cycle with preempt=1, then grant to idx 3 again, repeating.
5. With last=6 (after owner 6 releases), apply req=8'h41 → next grant is idx 0, not 6.
6. Assert rst mid-grant (idx 4) asynchronously between edges:
   - grant=8'h00 and grant_valid=0 immediately.
   - After release of reset with req=8'h90, the grant goes to idx 4.
